// File: rtl/decoder_pkg.sv
// Shared types for the sequenced one-hot decoder: command modes, FSM states, pulse flags.
// No logic here; latency and backpressure are defined by the blocks that import it.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // Registered single-cycle status pulses, bundled so they reset and default together.
  typedef struct packed {
    logic vld;
    logic done;
    logic err;
  } flags_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> NUM_OUT one-hot decoder with an in-range flag.
// Zero latency, no handshake; an out-of-range select decodes to all zeros.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  logic [SEL_W-1:0]   i_sel,
  output logic [NUM_OUT-1:0] o_onehot,
  output logic               o_in_range
);

  // One extra bit so NUM_OUT == 2**SEL_W is representable.
  localparam logic [SEL_W:0] LP_NUM_OUT = (SEL_W+1)'(NUM_OUT);

  assign o_in_range = ({1'b0, i_sel} < LP_NUM_OUT);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      o_onehot[i] = (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot / thermometer / walking-one scan decoder with range and mode error pulses.
// First dout one cycle after accept; cmd_ready drops only while a scan has beats still to issue.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [SEL_W-1:0]   cmd_sel,
  output logic [NUM_OUT-1:0] dout,
  output logic               dout_valid,
  output logic               done,
  output logic               err
);

  localparam logic [NUM_OUT-1:0] LP_ONEHOT0 = NUM_OUT'(1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [SEL_W-1:0]     r_cnt;
  logic [SEL_W-1:0]     w_cnt_nxt;
  logic [SEL_W-1:0]     r_sel_q;
  logic [SEL_W-1:0]     w_sel_q_nxt;
  logic [SEL_W-1:0]     w_cnt_inc;
  logic [SEL_W-1:0]     w_dec_sel;
  logic [NUM_OUT-1:0]   r_dout;
  logic [NUM_OUT-1:0]   w_dout_nxt;
  logic [NUM_OUT-1:0]   w_onehot;
  logic [NUM_OUT-1:0]   w_therm;
  logic                 w_in_range;
  logic                 w_accept;
  logic                 w_scan_start;
  logic                 w_scan_last;
  mode_e                w_mode;
  flags_t               r_flags;
  flags_t               w_flags_nxt;

  assign cmd_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_mode       = mode_e'(cmd_mode);
  assign w_cnt_inc    = r_cnt + SEL_W'(1);
  assign w_scan_last  = (w_cnt_inc == r_sel_q);

  // A single decoder serves both the command select and the scan position.
  assign w_dec_sel = (r_state == S_SCAN) ? w_cnt_inc : cmd_sel;

  onehot_dec #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .i_sel      (w_dec_sel),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign w_therm = (w_onehot - LP_ONEHOT0) | w_onehot;

  // A one-beat scan (sel 0) completes at accept and never leaves IDLE.
  assign w_scan_start = w_accept && w_in_range && (w_mode == MODE_SCAN) && (cmd_sel != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_scan_start) w_state_nxt = S_SCAN;
      S_SCAN: if (w_scan_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_dout_nxt  = r_dout;
    w_cnt_nxt   = r_cnt;
    w_sel_q_nxt = r_sel_q;
    w_flags_nxt = '0;
    case (r_state)
      S_SCAN: begin
        w_cnt_nxt        = w_cnt_inc;
        w_dout_nxt       = w_onehot;
        w_flags_nxt.vld  = 1'b1;
        w_flags_nxt.done = w_scan_last;
      end
      default: begin
        if (w_accept) begin
          // Range check outranks the reserved-mode check.
          if (!w_in_range) begin
            w_dout_nxt      = '0;
            w_flags_nxt.err = 1'b1;
          end else begin
            case (w_mode)
              MODE_DIRECT: begin
                w_dout_nxt       = w_onehot;
                w_flags_nxt.vld  = 1'b1;
                w_flags_nxt.done = 1'b1;
              end
              MODE_THERM: begin
                w_dout_nxt       = w_therm;
                w_flags_nxt.vld  = 1'b1;
                w_flags_nxt.done = 1'b1;
              end
              MODE_SCAN: begin
                w_dout_nxt       = LP_ONEHOT0;
                w_cnt_nxt        = '0;
                w_sel_q_nxt      = cmd_sel;
                w_flags_nxt.vld  = 1'b1;
                w_flags_nxt.done = (cmd_sel == '0);
              end
              default: begin
                w_flags_nxt.err  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_cnt   <= '0;
      r_sel_q <= '0;
      r_flags <= '0;
    end else begin
      r_dout  <= w_dout_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel_q <= w_sel_q_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_flags.vld;
  assign done       = r_flags.done;
  assign err        = r_flags.err;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench: driver pushes expected beats per accepted command, monitor pops on each strobe.
// Runs with NUM_OUT=20 so selects 20..31 exercise the out-of-range path.
module tb_onehot_decoder_seq;

  localparam int SW = 5;
  localparam int NO = 20;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [SW-1:0] cmd_sel;
  logic [NO-1:0] dout;
  logic          dout_valid;
  logic          done;
  logic          err;

  onehot_decoder_seq #(.SEL_W(SW), .NUM_OUT(NO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_sel    (cmd_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0] dout;
    logic          vld;
    logic          done;
    logic          err;
    logic          rdy;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [NO-1:0] m_dout = '0;
  logic [NO-1:0] hold = '0;
  bit            mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [NO-1:0] onehot_of(input int k);
    logic [63:0] v;
    v = 64'd1 << k;
    return v[NO-1:0];
  endfunction

  function automatic logic [NO-1:0] therm_of(input int k);
    logic [63:0] v;
    v = (64'd1 << (k + 1)) - 64'd1;
    return v[NO-1:0];
  endfunction

  task automatic push(input logic [NO-1:0] d, input logic v, input logic dn,
                      input logic er, input logic rd, input int c);
    exp_t e;
    e.dout = d; e.vld = v; e.done = dn; e.err = er; e.rdy = rd; e.cyc = c;
    q.push_back(e);
  endtask

  // Reference model: the expected beat list for one command accepted at this edge.
  task automatic model_push(input int mode, input int sel);
    int a;
    a = cyc;
    if (sel >= NO) begin
      push('0, 0, 0, 1, 1, a + 1);
      m_dout = '0;
    end else begin
      case (mode)
        0: begin m_dout = onehot_of(sel); push(m_dout, 1, 1, 0, 1, a + 1); end
        1: begin m_dout = therm_of(sel);  push(m_dout, 1, 1, 0, 1, a + 1); end
        2: begin
          for (int k = 0; k <= sel; k++)
            push(onehot_of(k), 1, k == sel, 0, k == sel, a + 1 + k);
          m_dout = onehot_of(sel);
        end
        default: push(m_dout, 0, 0, 1, 1, a + 1);
      endcase
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input int mode, input int sel);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    cmd_valid = 1'b1;
    cmd_mode  = 2'(mode);
    cmd_sel   = SW'(sel);
    while (!acc && n < 200) begin
      @(negedge clk);
      if (cmd_ready) acc = 1;
      else begin
        n++;
        @(posedge clk);
      end
    end
    if (acc) begin
      @(posedge clk);
      model_push(mode, sel);
      #1;
    end else begin
      n_chk++;
      $display("FAIL accept_timeout: mode %0d sel %0d never accepted", mode, sel);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    q.delete();
    m_dout = '0;
    hold = '0;
    mon_en = 1;
    @(negedge clk);
    check("rst_dout",       64'(dout),       64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_err",        64'(err),        64'd0);
    check("rst_cmd_ready",  64'(cmd_ready),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe consumes one expected beat; quiet cycles must hold dout.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dout_valid || done || err) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: dout %0h vld %0b done %0b err %0b with nothing expected (cycle %0d)",
                     dout, dout_valid, done, err, cyc);
          end else begin
            e = q.pop_front();
            check("beat_cycle", 64'(cyc),        64'(e.cyc));
            check("dout",       64'(dout),       64'(e.dout));
            check("dout_valid", 64'(dout_valid), 64'(e.vld));
            check("done",       64'(done),       64'(e.done));
            check("err",        64'(err),        64'(e.err));
            check("cmd_ready",  64'(cmd_ready),  64'(e.rdy));
            hold = e.dout;
          end
        end else begin
          check("dout_hold", 64'(dout), 64'(hold));
          if (q.size() > 0 && q[0].cyc <= cyc) begin
            n_chk++;
            $display("FAIL missing_beat: no strobe, expected dout %0h at cycle %0d, now %0d",
                     q[0].dout, q[0].cyc, cyc);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int gap;
    int w;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = '0;
    cmd_sel = '0;
    @(posedge clk);
    #1;
    do_reset();

    send(0, 5);  send(0, 19);           // back-to-back DIRECT, top line
    send(1, 3);  send(1, 0);  send(1, 19);
    send(2, 3);  send(0, 7);            // DIRECT accepted on the last scan beat
    send(0, 25);                        // out of range
    send(3, 2);                         // reserved mode, dout held
    send(0, 4);  send(3, 2);
    send(3, 25);                        // out of range wins over reserved
    send(2, 0);
    send(2, 5);  send(1, 4);            // valid held through a scan
    send(2, 19);
    send(2, 20);                        // out-of-range scan

    send(2, 10);
    repeat (4) @(posedge clk);
    #1;
    do_reset();                         // abort on beat 4

    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    w = 0;
    while (q.size() > 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Parametrised, registered successor to the team's 5-to-32 combinational one-hot decoder. It accepts select commands over a valid/ready handshake and produces one of three output forms on a registered `dout` bus: one-hot, thermometer, or a multi-cycle walking-one scan. It sits between control logic and banks of per-line enables, such as register-file write enables, channel strobes or LED/row drivers. It also flags out-of-range selects, which the old block could not do.

## Interface
Parameters:
- `SEL_W`, default 5. Width of the select field.
- `NUM_OUT`, default 32. Number of output lines; legal range is 2 ≤ `NUM_OUT` ≤ 2**`SEL_W`.

Ports:
- `clk`, input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`, input, 1 bit. Synchronous, active-high reset.
- `cmd_valid`, input, 1 bit. A command is presented.
- `cmd_ready`, output, 1 bit. Block can accept a command; equals `state==IDLE && !rst`.
- `cmd_mode`, input, 2 bits. 00 DIRECT, 01 THERM, 10 SCAN, 11 reserved.
- `cmd_sel`, input, `SEL_W` bits. Target line index.
- `dout`, output, `NUM_OUT` bits. Registered decoded output; holds its value between commands.
- `dout_valid`, output, 1 bit. 1-cycle strobe for each new `dout` value.
- `done`, output, 1 bit. 1-cycle pulse on the final beat of a successful command.
- `err`, output, 1 bit. 1-cycle pulse for a rejected command.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. The block samples `cmd_mode` and `cmd_sel` only at that edge.
- FSM states:
  - IDLE: the reset state; `cmd_ready` is high.
  - SCAN: `cmd_ready` is low.
- DIRECT:
  - `dout` takes bit `cmd_sel` set and all other bits clear.
  - `dout_valid` and `done` are high in the cycle after accept.
  - The FSM stays in IDLE, so back-to-back commands every cycle are legal.
- THERM:
  - `dout` takes bits `cmd_sel` down to 0 set and all higher bits clear.
  - Same timing as DIRECT.
- SCAN:
  - The sequence runs for `cmd_sel`+1 beats. Beat k, for k = 0..`cmd_sel`, drives `dout` with bit k set only, with `dout_valid` high on every beat.
  - At the accept edge: `dout` ← onehot(0) and `cnt` ← 0. The FSM moves to SCAN if `cmd_sel` > 0. If `cmd_sel` = 0, the FSM stays in IDLE and `done` is asserted with that single beat.
  - At each edge in SCAN: `cnt` ← `cnt`+1 and `dout` ← onehot(`cnt`+1). When `cnt`+1 == `sel_q`, the FSM moves to IDLE and `done` is set.
  - The FSM is therefore already in IDLE during the last beat, so `cmd_ready` is high and a new command may be accepted in the same cycle the last beat is displayed.
- Out-of-range select (`cmd_sel` ≥ `NUM_OUT`, any mode):
  - `err` is high in the cycle after accept, and `dout` ← 0.
  - `dout_valid` and `done` stay low, and the FSM remains in IDLE.
- Reserved mode 11: `err` is high in the cycle after accept. `dout` is unchanged and `dout_valid`/`done` stay low. This check applies when the select is in range; an out-of-range select follows the out-of-range rule above.
- `cnt` is `SEL_W` bits wide. It cannot overflow because `sel_q` < `NUM_OUT` ≤ 2**`SEL_W`.
- A `cmd_valid` while `cmd_ready` is low is ignored and not queued. The command source must hold the command until it is accepted.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `done` = 0, `err` = 0, state = IDLE, `cnt` = 0. `cmd_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Latency from accept edge to first `dout` is one cycle, in all modes.
- SCAN occupancy is `cmd_sel`+1 cycles of output. The next accept is possible at the edge that starts the last beat plus one cycle, so the minimum command period is `cmd_sel`+1 cycles.
- `dout_valid`, `done` and `err` are registered pulses. Each deasserts the cycle after it asserts unless a new event re-asserts it.
- Reset mid-SCAN aborts the scan: on the next edge all outputs take their reset values and no `done` is issued.
- `rst` has priority over a simultaneous `cmd_valid`; a command presented during reset is not accepted.

## Structure
- Shared package `decoder_pkg` contains:
  - the mode enum: `MODE_DIRECT`, `MODE_THERM`, `MODE_SCAN`, `MODE_RSVD`;
  - the state enum: `S_IDLE`, `S_SCAN`.
- Sub-module `onehot_dec`: a combinational, `SEL_W`→`NUM_OUT` one-hot decoder with a range-check output. It is instanced once, and the top level muxes its input between `cmd_sel` (accept) and `cnt`+1 (SCAN). The thermometer form is derived as `{onehot - 1} | onehot` at the top level.
- All outputs are driven directly from flops.

## Test plan
- Reset then DIRECT: DIRECT `cmd_sel`=5 → next cycle `dout`=0x0000_0020 with `dout_valid`=`done`=1. Then DIRECT 31 on the very next cycle → `dout`=0x8000_0000.
- THERM: THERM `cmd_sel`=3 → `dout`=0x0000_000F, `done`=1. THERM 0 → `dout`=0x1.
- SCAN: SCAN `cmd_sel`=3 → `dout` = 0x1, 0x2, 0x4, 0x8 on 4 consecutive cycles with `dout_valid` on all four. `done` and `cmd_ready` are high only on the 0x8 beat, and a DIRECT 7 accepted there appears as 0x80 in the following cycle.
- Errors, using `NUM_OUT`=20, `SEL_W`=5:
  - DIRECT 25 → `err` pulse, `dout`=0, no `done`.
  - Mode 11 with `cmd_sel`=2 → `err` pulse, `dout` unchanged.
- Reset mid-SCAN: SCAN 10, assert `rst` on beat 4 → all outputs 0 on the next cycle, no `done`, and `cmd_ready` returns to 1 after release.
- Stall: `cmd_valid` held during a SCAN 5 → the second command is accepted exactly at the last beat, and no command is lost or duplicated.
